// File: rtl/calc_pkg.sv
// Width helpers shared by the LED matrix datapath.
// The frame RAM write port is byte wide; its address is {row, column, byte}.
package calc_pkg;

    function automatic int num_data_a_bits();
        return 8;
    endfunction

    function automatic int num_address_a_bits(input int bytes_per_pixel,
                                              input int pixel_width,
                                              input int pixel_halfheight);
        return $clog2(bytes_per_pixel) + $clog2(pixel_width) + $clog2(2 * pixel_halfheight);
    endfunction

endpackage

// File: rtl/ctrl_pkg.sv
// Opcodes and decoder states for the LED panel command stream.
package ctrl_pkg;

    localparam logic [7:0] OP_RED_ON    = "R";
    localparam logic [7:0] OP_GREEN_ON  = "G";
    localparam logic [7:0] OP_BLUE_ON   = "B";
    localparam logic [7:0] OP_RED_OFF   = "r";
    localparam logic [7:0] OP_GREEN_OFF = "g";
    localparam logic [7:0] OP_BLUE_OFF  = "b";
    localparam logic [7:0] OP_BRIGHT    = "T";
    localparam logic [7:0] OP_FRAME     = "F";
    localparam logic [7:0] OP_LINE      = "L";
    localparam logic [7:0] OP_WATCHDOG  = "W";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_SEL,
        ST_ROW_DATA,
        ST_BRIGHT,
        ST_WD_SIG
    } state_t;

endpackage

// File: rtl/control_watchdog.sv
// Keep-alive watchdog: checks a multi-byte signature (MSB first), arms and
// reloads on a full match, then counts down and emits a one-cycle pulse on expiry.
module control_watchdog #(
    parameter int                            SIGNATURE_BITS    = 32,
    parameter logic [SIGNATURE_BITS-1:0]     SIGNATURE_PATTERN = 32'h5A5A_A5A5,
    parameter int                            CONTROL_TICKS     = 22_000_000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sig_start_i,
    input  logic       sig_valid_i,
    input  logic [7:0] sig_byte_i,
    output logic       sig_last_o,
    output logic       watchdog_reset_o
);

    localparam int SIG_BYTES = SIGNATURE_BITS / 8;
    localparam int IDX_W     = (SIG_BYTES > 1) ? $clog2(SIG_BYTES) : 1;
    localparam int CNT_W     = (CONTROL_TICKS > 1) ? $clog2(CONTROL_TICKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIG_BYTES - 1);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(CONTROL_TICKS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             match_q, match_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       expected_byte;
    logic             sig_hit;

    assign expected_byte    = SIGNATURE_PATTERN[8 * (SIG_BYTES - 1 - int'(idx_q)) +: 8];
    assign sig_hit          = (sig_byte_i == expected_byte);
    assign sig_last_o       = (idx_q == LAST_IDX);
    assign watchdog_reset_o = pulse_q;

    // Reload is evaluated after the countdown so a valid signature landing on
    // the expiry cycle suppresses the pulse.
    always_comb begin
        idx_d   = idx_q;
        match_d = match_q;
        armed_d = armed_q;
        count_d = count_q;
        pulse_d = 1'b0;

        if (armed_q) begin
            if (count_q == '0) begin
                pulse_d = 1'b1;
                armed_d = 1'b0;
                count_d = '0;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end

        if (sig_start_i) begin
            idx_d   = '0;
            match_d = 1'b1;
        end else if (sig_valid_i) begin
            if (sig_last_o) begin
                idx_d = '0;
                if (match_q && sig_hit) begin
                    armed_d = 1'b1;
                    count_d = RELOAD;
                    pulse_d = 1'b0;
                end
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                match_d = match_q && sig_hit;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            idx_q   <= '0;
            match_q <= 1'b1;
            armed_q <= 1'b0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            match_q <= match_d;
            armed_q <= armed_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/led_control_module.sv
// Byte-stream command decoder for the LED matrix: writes pixel rows to frame RAM
// and holds channel enables, brightness mask, frame select and the watchdog.
module led_control_module
    import ctrl_pkg::*;
#(
    parameter int BYTES_PER_PIXEL            = 2,
    parameter int PIXEL_WIDTH                = 64,
    parameter int PIXEL_HEIGHT               = 32,
    parameter int PIXEL_HALFHEIGHT           = 16,
    parameter int BRIGHTNESS_LEVELS          = 6,
    parameter int WATCHDOG_SIGNATURE_BITS    = 32,
    parameter logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN = 32'h5A5A_A5A5,
    parameter int WATCHDOG_CONTROL_TICKS     = 22_000_000,
    parameter int _UNUSED                    = 0
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [7:0]                    data_rx,
    input  logic                          data_ready_n,
    output logic                          busy,
    output logic                          ready_for_data,
    output logic [2:0]                    rgb_enable,
    output logic [BRIGHTNESS_LEVELS-1:0]  brightness_enable,
    output logic                          frame_select,
    output logic                          watchdog_reset,
    output logic [calc_pkg::num_data_a_bits()-1:0] ram_data_out,
    output logic [calc_pkg::num_address_a_bits(BYTES_PER_PIXEL, PIXEL_WIDTH, PIXEL_HALFHEIGHT)-1:0] ram_address,
    output logic                          ram_write_enable,
    output logic                          ram_clk_enable,
    output logic [7:0]                    num_commands_processed
);

    localparam int ROW_W  = $clog2(PIXEL_HEIGHT);
    localparam int COL_W  = $clog2(PIXEL_WIDTH);
    localparam int BYTE_W = $clog2(BYTES_PER_PIXEL);
    localparam int ADDR_W = calc_pkg::num_address_a_bits(BYTES_PER_PIXEL, PIXEL_WIDTH, PIXEL_HALFHEIGHT);
    localparam int DATA_W = calc_pkg::num_data_a_bits();

    // The ignored _UNUSED parameter is folded into this check so it is referenced.
    if (PIXEL_HALFHEIGHT * 2 != PIXEL_HEIGHT + (_UNUSED * 0)) begin : g_bad_halfheight
        $error("PIXEL_HALFHEIGHT must equal PIXEL_HEIGHT/2");
    end

    state_t                         state_q;
    logic [ROW_W-1:0]               row_q;
    logic [COL_W-1:0]               col_q;
    logic [BYTE_W-1:0]              byte_q;
    logic [2:0]                     rgb_q;
    logic [BRIGHTNESS_LEVELS-1:0]   bright_q;
    logic                           frame_q;
    logic [DATA_W-1:0]              ram_data_q;
    logic [ADDR_W-1:0]              ram_addr_q;
    logic                           ram_we_q;
    logic [7:0]                     cmd_count_q;

    logic                           sig_start;
    logic                           sig_valid;
    logic                           sig_last;

    assign sig_start = data_ready_n && (state_q == ST_IDLE) && (data_rx == OP_WATCHDOG);
    assign sig_valid = data_ready_n && (state_q == ST_WD_SIG);

    control_watchdog #(
        .SIGNATURE_BITS    (WATCHDOG_SIGNATURE_BITS),
        .SIGNATURE_PATTERN (WATCHDOG_SIGNATURE_PATTERN),
        .CONTROL_TICKS     (WATCHDOG_CONTROL_TICKS)
    ) u_watchdog (
        .clk_in           (clk_in),
        .reset            (reset),
        .sig_start_i      (sig_start),
        .sig_valid_i      (sig_valid),
        .sig_byte_i       (data_rx),
        .sig_last_o       (sig_last),
        .watchdog_reset_o (watchdog_reset)
    );

    // Every strobe is consumed by whichever state is current; row bytes are
    // addressed column-descending with the byte index changing fastest.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            byte_q      <= '0;
            rgb_q       <= 3'b111;
            bright_q    <= '1;
            frame_q     <= 1'b0;
            ram_data_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            if (data_ready_n) begin
                case (state_q)
                    ST_IDLE: begin
                        case (data_rx)
                            OP_RED_ON:    begin rgb_q[2] <= 1'b1; cmd_count_q <= cmd_count_q + 8'd1; end
                            OP_GREEN_ON:  begin rgb_q[1] <= 1'b1; cmd_count_q <= cmd_count_q + 8'd1; end
                            OP_BLUE_ON:   begin rgb_q[0] <= 1'b1; cmd_count_q <= cmd_count_q + 8'd1; end
                            OP_RED_OFF:   begin rgb_q[2] <= 1'b0; cmd_count_q <= cmd_count_q + 8'd1; end
                            OP_GREEN_OFF: begin rgb_q[1] <= 1'b0; cmd_count_q <= cmd_count_q + 8'd1; end
                            OP_BLUE_OFF:  begin rgb_q[0] <= 1'b0; cmd_count_q <= cmd_count_q + 8'd1; end
                            OP_FRAME:     begin frame_q <= ~frame_q; cmd_count_q <= cmd_count_q + 8'd1; end
                            OP_BRIGHT:    state_q <= ST_BRIGHT;
                            OP_LINE:      state_q <= ST_ROW_SEL;
                            OP_WATCHDOG:  state_q <= ST_WD_SIG;
                            default:      ;
                        endcase
                    end
                    ST_ROW_SEL: begin
                        row_q   <= data_rx[ROW_W-1:0];
                        col_q   <= COL_W'(PIXEL_WIDTH - 1);
                        byte_q  <= BYTE_W'(BYTES_PER_PIXEL - 1);
                        state_q <= ST_ROW_DATA;
                    end
                    ST_ROW_DATA: begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= {row_q, col_q, byte_q};
                        ram_data_q <= data_rx;
                        if (byte_q == '0) begin
                            if (col_q == '0) begin
                                state_q     <= ST_IDLE;
                                cmd_count_q <= cmd_count_q + 8'd1;
                            end else begin
                                col_q  <= col_q - 1'b1;
                                byte_q <= BYTE_W'(BYTES_PER_PIXEL - 1);
                            end
                        end else begin
                            byte_q <= byte_q - 1'b1;
                        end
                    end
                    ST_BRIGHT: begin
                        bright_q    <= data_rx[BRIGHTNESS_LEVELS-1:0];
                        state_q     <= ST_IDLE;
                        cmd_count_q <= cmd_count_q + 8'd1;
                    end
                    ST_WD_SIG: begin
                        if (sig_last) begin
                            state_q     <= ST_IDLE;
                            cmd_count_q <= cmd_count_q + 8'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy                   = (state_q != ST_IDLE);
    assign ready_for_data         = ~busy;
    assign rgb_enable             = rgb_q;
    assign brightness_enable      = bright_q;
    assign frame_select           = frame_q;
    assign ram_data_out           = ram_data_q;
    assign ram_address            = ram_addr_q;
    assign ram_write_enable       = ram_we_q;
    assign ram_clk_enable         = ram_we_q;
    assign num_commands_processed = cmd_count_q;

endmodule

// File: tb/tb_led_control_module.sv
// Scenario bench for led_control_module; RAM writes are scoreboarded against a
// queue filled as row bytes are driven.
module tb_led_control_module;

    localparam int TICKS  = 100;
    localparam int ADDR_W = 12;

    logic              clk_in = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        data_rx = 8'h00;
    logic              data_ready_n = 1'b0;
    logic              busy, ready_for_data, frame_select, watchdog_reset;
    logic [2:0]        rgb_enable;
    logic [5:0]        brightness_enable;
    logic [7:0]        ram_data_out;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_write_enable, ram_clk_enable;
    logic [7:0]        num_commands_processed;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_item;
    int         checks = 0;
    int         errors = 0;
    int         nwrites = 0;
    int         cyc = 0;
    int         pulse_total = 0;
    int         pulse_cyc = 0;
    bit         mon_en = 1'b0;
    logic [2:0] exp_rgb = 3'b111;
    logic [5:0] exp_bright = 6'h3f;
    logic       exp_fs = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    led_control_module #(
        .WATCHDOG_CONTROL_TICKS(TICKS)
    ) dut (
        .clk_in                 (clk_in),
        .reset                  (reset),
        .data_rx                (data_rx),
        .data_ready_n           (data_ready_n),
        .busy                   (busy),
        .ready_for_data         (ready_for_data),
        .rgb_enable             (rgb_enable),
        .brightness_enable      (brightness_enable),
        .frame_select           (frame_select),
        .watchdog_reset         (watchdog_reset),
        .ram_data_out           (ram_data_out),
        .ram_address            (ram_address),
        .ram_write_enable       (ram_write_enable),
        .ram_clk_enable         (ram_clk_enable),
        .num_commands_processed (num_commands_processed)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // RAM write scoreboard and watchdog pulse monitor, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (watchdog_reset === 1'b1) begin
            pulse_total = pulse_total + 1;
            pulse_cyc   = cyc;
        end
        if (mon_en) begin
            checks++;
            if (ram_clk_enable !== ram_write_enable) begin
                errors++;
                $display("[TB] FAIL clk_enable: got %b, expected %b", ram_clk_enable, ram_write_enable);
            end
            if (ram_write_enable === 1'b1) begin
                nwrites++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write", ram_address, ram_data_out);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({ram_address, ram_data_out} !== exp_item) begin
                        errors++;
                        $display("[TB] FAIL ram_write: got addr %h data %h, expected addr %h data %h",
                                 ram_address, ram_data_out, exp_item.addr, exp_item.data);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk_in);
        data_rx      = b;
        data_ready_n = 1'b1;
    endtask

    task automatic idleBus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            data_ready_n = 1'b0;
        end
    endtask

    // Single-byte opcode model; returns through the exp_* variables.
    task automatic modelOpcode(input logic [7:0] b);
        case (b)
            "R": begin exp_rgb[2] = 1'b1; exp_cnt++; end
            "G": begin exp_rgb[1] = 1'b1; exp_cnt++; end
            "B": begin exp_rgb[0] = 1'b1; exp_cnt++; end
            "r": begin exp_rgb[2] = 1'b0; exp_cnt++; end
            "g": begin exp_rgb[1] = 1'b0; exp_cnt++; end
            "b": begin exp_rgb[0] = 1'b0; exp_cnt++; end
            "F": begin exp_fs = ~exp_fs; exp_cnt++; end
            default: ;
        endcase
    endtask

    function automatic wr_t rowWrite(input int row, input int k);
        wr_t w;
        w.addr = {5'(row % 32), 6'(63 - k / 2), 1'(1 - k % 2)};
        w.data = 8'h30 + 8'(7 - k % 8);
        return w;
    endfunction

    task automatic checkControl(input string name);
        checks++;
        if (rgb_enable !== exp_rgb) begin
            errors++;
            $display("[TB] FAIL %s rgb_enable: got %b, expected %b", name, rgb_enable, exp_rgb);
        end
        checks++;
        if (num_commands_processed !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL %s counter: got %0d, expected %0d", name, num_commands_processed, exp_cnt);
        end
        checks++;
        if (brightness_enable !== exp_bright || frame_select !== exp_fs) begin
            errors++;
            $display("[TB] FAIL %s bright/frame: got %b/%b, expected %b/%b", name,
                     brightness_enable, frame_select, exp_bright, exp_fs);
        end
        checks++;
        if (busy !== 1'b0 || ready_for_data !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s idle: got busy %b ready %b, expected 0 1", name, busy, ready_for_data);
        end
    endtask

    task automatic checkResetValues(input string name);
        exp_rgb = 3'b111; exp_bright = 6'h3f; exp_fs = 1'b0; exp_cnt = 8'd0;
        checkControl(name);
        checks++;
        if (ram_write_enable !== 1'b0 || ram_address !== '0 || ram_data_out !== 8'h00 || watchdog_reset !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s ram/wd: got we %b addr %h data %h wd %b, expected all 0", name,
                     ram_write_enable, ram_address, ram_data_out, watchdog_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data_ready_n = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        checkResetValues("reset");
        mon_en = 1'b1;
    endtask

    task automatic test_row();
        string ops = "brR ";
        int    base;
        for (int i = 0; i < ops.len(); i++) begin
            applyStimulus(ops[i]);
            idleBus(1);
            modelOpcode(ops[i]);
            checkControl("row_opcodes");
        end
        base = nwrites;
        applyStimulus("L");
        applyStimulus("-");
        checks++;
        if (busy !== 1'b1 || ready_for_data !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_rise: got busy %b ready %b, expected 1 0", busy, ready_for_data);
        end
        for (int k = 0; k < 128; k++) begin
            if (k == 64) idleBus(3);
            exp_q.push_back(rowWrite(45, k));
            applyStimulus(8'h30 + 8'(7 - k % 8));
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy_row byte %0d: got %b, expected 1", k, busy);
            end
        end
        idleBus(1);
        exp_cnt++;
        checkControl("row_done");
        idleBus(2);
        checks++;
        if (nwrites - base !== 128 || exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL row_writes: got %0d writes, %0d pending, expected 128, 0", nwrites - base, exp_q.size());
        end
    endtask

    task automatic test_brightness();
        logic [7:0] vals [2] = '{8'h15, 8'hC0};
        for (int i = 0; i < 2; i++) begin
            applyStimulus("T");
            applyStimulus(vals[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bright_busy: got %b, expected 1", busy);
            end
            idleBus(1);
            exp_bright = vals[i][5:0];
            exp_cnt++;
            checkControl("brightness");
        end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 2; i++) begin
            applyStimulus("F");
            idleBus(1);
            modelOpcode("F");
            checkControl("frame");
        end
    endtask

    task automatic test_unknown();
        applyStimulus("X");
        applyStimulus(" ");
        idleBus(1);
        checkControl("unknown");
    endtask

    task automatic sendSignature(input logic [31:0] sig);
        applyStimulus("W");
        for (int i = 3; i >= 0; i--) applyStimulus(sig[8*i +: 8]);
        exp_cnt++;
    endtask

    task automatic test_watchdog();
        int p0, start;
        p0 = pulse_total;
        sendSignature(32'h5A5A_A5A5);
        idleBus(1);
        start = cyc;
        checkControl("wd_sig");
        idleBus(150);
        checks++;
        if (pulse_total - p0 !== 1) begin
            errors++;
            $display("[TB] FAIL wd_pulse_count: got %0d, expected 1", pulse_total - p0);
        end
        checks++;
        if (pulse_cyc - start < TICKS - 1 || pulse_cyc - start > TICKS + 1) begin
            errors++;
            $display("[TB] FAIL wd_pulse_time: got %0d cycles, expected %0d+-1", pulse_cyc - start, TICKS);
        end
    endtask

    task automatic test_watchdog_keepalive();
        int p0;
        p0 = pulse_total;
        sendSignature(32'h5A5A_A5A5);
        for (int r = 0; r < 4; r++) begin
            idleBus(45);
            sendSignature(32'h5A5A_A5A5);
        end
        idleBus(45);
        checks++;
        if (pulse_total - p0 !== 0) begin
            errors++;
            $display("[TB] FAIL wd_keepalive: got %0d pulses, expected 0", pulse_total - p0);
        end
        checkControl("wd_keepalive");
        idleBus(100);
        checks++;
        if (pulse_total - p0 !== 1) begin
            errors++;
            $display("[TB] FAIL wd_keepalive_expire: got %0d pulses, expected 1", pulse_total - p0);
        end
    endtask

    task automatic test_watchdog_mismatch();
        int p0;
        p0 = pulse_total;
        sendSignature(32'h5A5A_A5A4);
        sendSignature(32'h005A_A5A5);
        idleBus(1);
        checkControl("wd_mismatch");
        idleBus(150);
        checks++;
        if (pulse_total - p0 !== 0) begin
            errors++;
            $display("[TB] FAIL wd_mismatch: got %0d pulses, expected 0", pulse_total - p0);
        end
    endtask

    task automatic test_reset_mid_row();
        applyStimulus("F");
        idleBus(1);
        modelOpcode("F");
        checkControl("pre_reset");
        applyStimulus("L");
        applyStimulus("-");
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(rowWrite(45, k));
            applyStimulus(8'h30 + 8'(7 - k % 8));
        end
        @(negedge clk_in);
        data_ready_n = 1'b0;
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        checkResetValues("reset_mid_row");
        applyStimulus("g");
        idleBus(1);
        modelOpcode("g");
        checkControl("after_reset");
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL partial_row: got %0d pending writes, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_row();
        test_brightness();
        test_frame();
        test_unknown();
        test_watchdog();
        test_watchdog_keepalive();
        test_watchdog_mismatch();
        test_reset_mid_row();
        idleBus(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: got no completion, expected finish before 1 ms");
        $fatal(1, "[TB] timeout");
    end

endmodule
